// File: rtl/demux12_pkg.sv
// demux12_pkg: shared defaults and width helpers for the 1-to-2 demux FIFO block.
// Optional pop statistics are enabled with the DEMUX12_STATS_EN macro (see demux12).
package demux12_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 2;

   // Widths for the default depth; instances with another DEPTH use the helpers.
   localparam int PTR_W   = $clog2(DEF_DEPTH);
   localparam int CNT_W   = $clog2(DEF_DEPTH + 1);
   localparam int STATS_W = 16;

   // Pointer width for a given depth; never below one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/demux12_fifo.sv
// demux12_fifo: one output queue of demux12. Registered storage, wrapping
// read/write pointers and an occupancy count that sources full/empty.
// Push is ignored when full and pop is ignored when empty, so callers never
// corrupt the pointers.
module demux12_fifo
   import demux12_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage write; every entry is cleared on reset so dout reads 0 until refilled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap at DEPTH-1 explicitly, so wrap is correct even at the pointer MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy: simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/demux12.sv
// demux12: steers a valid/ready input stream into one of two output FIFOs
// chosen by sel. One cycle of latency, no combinational din-to-dout path,
// and no pass-through when the selected FIFO is full.
// Optional build macro DEMUX12_STATS_EN adds 16-bit per-output pop counters
// cnt_0/cnt_1; without it those ports do not exist.
module demux12
   import demux12_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sel,
   input  logic [WIDTH-1:0]   din,
   input  logic               din_valid,
   output logic               din_ready,
   output logic [WIDTH-1:0]   dout_0,
   output logic               dout_0_valid,
   input  logic               dout_0_ready,
   output logic [WIDTH-1:0]   dout_1,
   output logic               dout_1_valid,
   input  logic               dout_1_ready
`ifdef DEMUX12_STATS_EN
   ,
   output logic [STATS_W-1:0] cnt_0,
   output logic [STATS_W-1:0] cnt_1
`endif
);

   logic full_0;
   logic full_1;
   logic empty_0;
   logic empty_1;
   logic push_0;
   logic push_1;
   logic pop_0;
   logic pop_1;

   // Ready looks only at the selected FIFO's fullness; a same-cycle pop does not
   // free the slot, which keeps din_ready off any dout_k_ready path.
   always_comb begin
      din_ready = 1'b0;
      push_0    = 1'b0;
      push_1    = 1'b0;
      if (sel) begin
         din_ready = !full_1;
         push_1    = din_valid && !full_1;
      end else begin
         din_ready = !full_0;
         push_0    = din_valid && !full_0;
      end
   end

   assign dout_0_valid = !empty_0;
   assign dout_1_valid = !empty_1;
   assign pop_0        = dout_0_valid && dout_0_ready;
   assign pop_1        = dout_1_valid && dout_1_ready;

   demux12_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo_0 (
      .clk   (clk),
      .rst   (rst),
      .push  (push_0),
      .wdata (din),
      .pop   (pop_0),
      .full  (full_0),
      .empty (empty_0),
      .head  (dout_0)
   );

   demux12_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo_1 (
      .clk   (clk),
      .rst   (rst),
      .push  (push_1),
      .wdata (din),
      .pop   (pop_1),
      .full  (full_1),
      .empty (empty_1),
      .head  (dout_1)
   );

`ifdef DEMUX12_STATS_EN
   // Pop counters wrap naturally at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_0 <= '0;
         cnt_1 <= '0;
      end else begin
         if (pop_0) begin
            cnt_0 <= cnt_0 + 1'b1;
         end
         if (pop_1) begin
            cnt_1 <= cnt_1 + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_demux12.sv
// tb_demux12: self-checking bench for demux12 (default WIDTH=32, DEPTH=2).
// Define DEMUX12_STATS_EN to also check the pop counters.
module tb_demux12;

   localparam int W = 32;
   localparam int D = 2;

   logic         clk;
   logic         rst;
   logic         sel;
   logic [W-1:0] din;
   logic         din_valid;
   logic         din_ready;
   logic [W-1:0] dout_0;
   logic         dout_0_valid;
   logic         dout_0_ready;
   logic [W-1:0] dout_1;
   logic         dout_1_valid;
   logic         dout_1_ready;
`ifdef DEMUX12_STATS_EN
   logic [15:0]  cnt_0;
   logic [15:0]  cnt_1;
`endif

   demux12 #(
      .WIDTH (W),
      .DEPTH (D)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sel          (sel),
      .din          (din),
      .din_valid    (din_valid),
      .din_ready    (din_ready),
      .dout_0       (dout_0),
      .dout_0_valid (dout_0_valid),
      .dout_0_ready (dout_0_ready),
      .dout_1       (dout_1),
      .dout_1_valid (dout_1_valid),
      .dout_1_ready (dout_1_ready)
`ifdef DEMUX12_STATS_EN
      ,
      .cnt_0        (cnt_0),
      .cnt_1        (cnt_1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         sel;
      logic [W-1:0] din;
      logic         v;
      logic         r0;
      logic         r1;
      logic         exp_rdy;
      logic         exp_v0;
      logic [W-1:0] exp_d0;
      logic         exp_v1;
      logic [W-1:0] exp_d1;
   } vec_t;

   vec_t         tbl [14];
   logic [W-1:0] q0 [$];
   logic [W-1:0] q1 [$];
   int           n_tests;
   int           n_fail;
   int           exp_cnt0;
   int           exp_cnt1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [W-1:0] d, input logic v,
                        input logic a, input logic b);
      @(negedge clk);
      sel          = s;
      din          = d;
      din_valid    = v;
      dout_0_ready = a;
      dout_1_ready = b;
      #1;
   endtask

   // Compare a DUT pop against the scoreboard head (sampled before the edge).
   task automatic sb_pop0();
      if (dout_0_ready && q0.size() > 0) begin
         check("sb dout_0", dout_0, q0.pop_front());
         exp_cnt0++;
      end
   endtask

   task automatic sb_pop1();
      if (dout_1_ready && q1.size() > 0) begin
         check("sb dout_1", dout_1, q1.pop_front());
         exp_cnt1++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic         pv0;
      logic         pv1;
      logic         exp_rdy;
      logic         s;
      logic         a;
      logic         b;
      logic [W-1:0] w;
      int           accepted;
      int           popped;
      int           cyc;

      n_tests  = 0;
      n_fail   = 0;
      exp_cnt0 = 0;
      exp_cnt1 = 0;

      //            sel   din           v     r0    r1    rdy   v0    d0            v1    d1
      tbl[0]  = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'h12345678};
      tbl[2]  = '{1'b0, 32'h000000A1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'h12345678};
      tbl[3]  = '{1'b0, 32'h000000A2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 32'h12345678};
      tbl[4]  = '{1'b1, 32'h000000A2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'h12345678};
      tbl[5]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h000000A1, 1'b1, 32'h000000A2};
      tbl[6]  = '{1'b0, 32'h000000B1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h000000B1, 1'b1, 32'h000000A2};
      tbl[7]  = '{1'b1, 32'h000000C1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000B1, 1'b1, 32'h000000A2};
      tbl[8]  = '{1'b1, 32'h000000C2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h000000B1, 1'b1, 32'h000000C1};
      tbl[9]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0};
      tbl[10] = '{1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0};
      tbl[11] = '{1'b0, 32'h000000D1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000D1, 1'b0, 32'h0};
      tbl[12] = '{1'b0, 32'h000000D2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000D1, 1'b0, 32'h0};
      tbl[13] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h000000D2, 1'b0, 32'h0};

      // Reset held with random inputs: outputs stay cleared.
      rst = 1'b1;
      sel = 1'b0; din = '0; din_valid = 1'b0; dout_0_ready = 1'b0; dout_1_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("rst dout_0_valid", dout_0_valid, 0);
         check("rst dout_1_valid", dout_1_valid, 0);
         check("rst dout_0", dout_0, 0);
         check("rst dout_1", dout_1, 0);
      end
      @(negedge clk);
      rst = 1'b0; din_valid = 1'b0; sel = 1'b0;
      #1 check("post-rst din_ready sel0", din_ready, 1);
      sel = 1'b1;
      #1 check("post-rst din_ready sel1", din_ready, 1);

      // Directed table: steering, backpressure, simultaneous push/pop, wrap.
      pv0 = 1'b0;
      pv1 = 1'b0;
      foreach (tbl[i]) begin
         drive(tbl[i].sel, tbl[i].din, tbl[i].v, tbl[i].r0, tbl[i].r1);
         check($sformatf("tbl%0d din_ready", i), din_ready, tbl[i].exp_rdy);
         if (tbl[i].r0 && pv0) exp_cnt0++;
         if (tbl[i].r1 && pv1) exp_cnt1++;
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d dout_0_valid", i), dout_0_valid, tbl[i].exp_v0);
         check($sformatf("tbl%0d dout_1_valid", i), dout_1_valid, tbl[i].exp_v1);
         if (tbl[i].exp_v0) check($sformatf("tbl%0d dout_0", i), dout_0, tbl[i].exp_d0);
         if (tbl[i].exp_v1) check($sformatf("tbl%0d dout_1", i), dout_1, tbl[i].exp_d1);
         pv0 = tbl[i].exp_v0;
         pv1 = tbl[i].exp_v1;
      end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      if (pv0) exp_cnt0++;
      @(posedge clk);
      #1 check("tbl drain dout_0_valid", dout_0_valid, 0);

      // Stream: 100 words alternating sel, random readies, scoreboard per output.
      q0.delete();
      q1.delete();
      accepted = 0;
      popped   = 0;
      cyc      = 0;
      w        = $urandom;
      while (accepted < 100 && cyc < 3000) begin
         cyc++;
         s = accepted[0];
         a = 1'($urandom_range(0, 1));
         b = 1'($urandom_range(0, 1));
         drive(s, w, 1'b1, a, b);
         exp_rdy = s ? (q1.size() < D) : (q0.size() < D);
         check("stream din_ready", din_ready, exp_rdy);
         check("stream dout_0_valid", dout_0_valid, q0.size() > 0);
         check("stream dout_1_valid", dout_1_valid, q1.size() > 0);
         if (a && q0.size() > 0) popped++;
         if (b && q1.size() > 0) popped++;
         sb_pop0();
         sb_pop1();
         @(posedge clk);
         if (exp_rdy) begin
            if (s) q1.push_back(w);
            else   q0.push_back(w);
            accepted++;
            w = $urandom;
         end
      end
      check("stream words accepted", accepted, 100);
      cyc = 0;
      while ((q0.size() > 0 || q1.size() > 0) && cyc < 20) begin
         cyc++;
         drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
         check("drain dout_0_valid", dout_0_valid, q0.size() > 0);
         check("drain dout_1_valid", dout_1_valid, q1.size() > 0);
         if (q0.size() > 0) popped++;
         if (q1.size() > 0) popped++;
         sb_pop0();
         sb_pop1();
         @(posedge clk);
      end
      #1;
      check("stream words popped", popped, 100);
      check("stream end dout_0_valid", dout_0_valid, 0);
      check("stream end dout_1_valid", dout_1_valid, 0);
`ifdef DEMUX12_STATS_EN
      check("stream cnt_0", cnt_0, exp_cnt0[15:0]);
      check("stream cnt_1", cnt_1, exp_cnt1[15:0]);
`endif

      // Reset mid-operation: contents discarded asynchronously.
      drive(1'b0, 32'h55550001, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'h55550002, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1 check("pre-rst dout_1_valid", dout_1_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("mid-rst dout_0_valid", dout_0_valid, 0);
      check("mid-rst dout_1_valid", dout_1_valid, 0);
      check("mid-rst dout_0", dout_0, 0);
      check("mid-rst dout_1", dout_1, 0);
`ifdef DEMUX12_STATS_EN
      check("mid-rst cnt_0", cnt_0, 0);
      check("mid-rst cnt_1", cnt_1, 0);
`endif
      @(negedge clk);
      rst = 1'b0; din_valid = 1'b0; sel = 1'b0;
      #1 check("rst2 din_ready sel0", din_ready, 1);
      sel = 1'b1;
      #1 check("rst2 din_ready sel1", din_ready, 1);
      q0.delete();
      q1.delete();
      exp_cnt0 = 0;
      exp_cnt1 = 0;

      // Five words through output 0 and three through output 1, consumer always ready.
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 32'hA000_0000 + W'(i), 1'b1, 1'b1, 1'b0);
         sb_pop0();
         @(posedge clk);
         q0.push_back(32'hA000_0000 + W'(i));
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'hB000_0000 + W'(i), 1'b1, 1'b1, 1'b1);
         sb_pop0();
         sb_pop1();
         @(posedge clk);
         q1.push_back(32'hB000_0000 + W'(i));
      end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      sb_pop0();
      sb_pop1();
      @(posedge clk);
      #1;
      check("pops out0", exp_cnt0, 5);
      check("pops out1", exp_cnt1, 3);
      check("final dout_0_valid", dout_0_valid, 0);
      check("final dout_1_valid", dout_1_valid, 0);
`ifdef DEMUX12_STATS_EN
      check("stats cnt_0", cnt_0, 16'd5);
      check("stats cnt_1", cnt_1, 16'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/demux12.md
DEMUX12 -- requirements
Module: demux12

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, meaning entries per output FIFO (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port sel  input  1  destination select: 0 selects output 0, 1 selects output 1.
REQ-006 SHALL have port din  input  WIDTH  input data word.
REQ-007 SHALL have port din_valid  input  1  input word present.
REQ-008 SHALL have port din_ready  output  1  block can accept the word toward the selected output.
REQ-009 SHALL have port dout_0 / dout_1  output  WIDTH each  head-of-FIFO data, per output.
REQ-010 SHALL have port dout_0_valid / dout_1_valid  output  1 each  head entry present.
REQ-011 SHALL have port dout_0_ready / dout_1_ready  input  1 each  consumer takes the head entry.

Function
REQ-012 SHALL assert din_ready combinationally when FIFO[sel] is not full; it depends only on sel and FIFO state, never on din_valid.
REQ-013 SHALL push din into FIFO[sel] on a clock edge where din_valid && din_ready; the other FIFO is untouched.
REQ-014 SHALL drive dout_k_valid = 1 when FIFO k is non-empty, and dout_k = FIFO k head entry.
REQ-015 SHALL pop FIFO k on a clock edge where dout_k_valid && dout_k_ready.
REQ-016 SHALL have latency exactly 1 cycle: a word accepted at edge N is visible on dout_k from just after edge N; no combinational din-to-dout path.
REQ-017 SHALL allow push and pop of the same FIFO on the same edge (count unchanged); with FIFO full, din_ready is 0 even if a pop occurs that cycle (no pass-through).
REQ-018 SHALL allow both FIFOs to pop on the same edge, independently.
REQ-019 SHALL wrap read/write pointers modulo DEPTH; full and empty are derived from an occupancy count 0..DEPTH.
REQ-020 SHALL ignore dout_k_ready while FIFO k is empty, with no state change and no underflow.
REQ-021 SHALL preserve order per output; ordering across outputs is not defined.
REQ-022 SHALL require the source to hold din and sel stable while din_valid && !din_ready; a change of sel while stalled is legal and re-evaluates din_ready.

Reset
REQ-023 SHALL, while rst=1, clear both FIFOs asynchronously: pointers 0, counts 0, dout_k_valid=0, dout_k=0, and all storage entries 0.
REQ-024 SHALL, after rst deasserts, present din_ready=1 for either sel value.
REQ-025 SHALL discard in-flight contents on reset mid-operation; nothing is replayed.

Configuration
REQ-026 SHALL, when DEMUX12_STATS_EN is defined, add outputs cnt_0 and cnt_1 (16 bits each), counting pops per output, wrapping 0xFFFF->0, cleared by rst.
REQ-027 SHALL, without DEMUX12_STATS_EN, omit cnt_0/cnt_1 entirely, with all other behaviour identical.

Structure
REQ-028 SHALL place the WIDTH/DEPTH defaults, the pointer-width constant (clog2 DEPTH), the count-width constant, and the stats counter width (16) in shared package demux12_pkg.
REQ-029 SHALL implement each output queue as sub-module demux12_fifo (push/pop/full/empty/head, async active-high rst), instantiated twice; steering logic stays in demux12.

Verification
REQ-030 Reset: hold rst=1 with random inputs -> dout_0_valid=dout_1_valid=0, dout_0=dout_1=0, din_ready=1 after release.
REQ-031 Steering: push 0xDEADBEEF sel=0, then 0x12345678 sel=1, both readies 0 -> dout_0=0xDEADBEEF and dout_1=0x12345678 one cycle after each push; the other output is unaffected.
REQ-032 Full/backpressure: push 3 words with sel=0 and dout_0_ready=0 -> third word sees din_ready=0 after 2 accepts; with sel switched to 1, din_ready=1 and the word lands in FIFO 1.
REQ-033 Simultaneous: FIFO 0 holds 1 entry, push sel=0 with dout_0_ready=1 on the same edge -> count stays 1, head becomes the new word, order preserved.
REQ-034 Wrap/stream: 100 words alternating sel, random readies -> each output emits its words in order with no loss or duplication; pointers wrap correctly.
REQ-035 Stats (DEMUX12_STATS_EN): 5 pops on output 0, 3 on output 1 -> cnt_0=5, cnt_1=3; rst mid-stream -> both 0.
